// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - state encoding and frame timing constants shared by the uart_rx slice
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [3:0] OVERSAMPLE_LAST = 4'd15;
    localparam logic [3:0] MID_SAMPLE      = 4'd7;
    localparam int         DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, tick strobe and received-byte status bundle for uart_rx
interface uart_rx_if;

    logic       rxclk_en;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output rxclk_en, rx, rdy_clr,
        input  data, rdy, frame_err, overrun, parity_err
    );

    modport slave (
        input  rxclk_en, rx, rdy_clr,
        output data, rdy, frame_err, overrun, parity_err
    );

endinterface

// File: rtl/uart_rx_sync2.sv
// rtl/uart_rx_sync2.sv - two-flop synchroniser for the async rx line, resets to the idle level
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled 8N1 UART receiver; UART_RX_PARITY_EN adds a parity bit before stop
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = int'(OVERSAMPLE_LAST) + 1
`ifdef UART_RX_PARITY_EN
   ,parameter bit PARITY_ODD = 1'b0
`endif
) (
    input logic     clock50,
    input logic     reset,
    uart_rx_if.slave bus
);

    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic       rx_s;
    rx_state_t  state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_q, data_n;
    logic       rdy_q, rdy_n;
    logic       frame_err_q, frame_err_n;
    logic       overrun_q, overrun_n;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_q, parity_err_n;
`endif

    sync2 u_sync (
        .clk (clock50),
        .rst (reset),
        .d   (bus.rx),
        .q   (rx_s)
    );

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            data_q      <= data_n;
            rdy_q       <= rdy_n;
            frame_err_q <= frame_err_n;
            overrun_q   <= overrun_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_err_n;
    end
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        data_n      = data_q;
        rdy_n       = rdy_q;
        frame_err_n = frame_err_q;
        overrun_n   = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_n = parity_err_q;
`endif

        // The bus-side clear is not gated by the tick; a byte landing in the same clock overrides it.
        if (bus.rdy_clr) begin
            rdy_n     = 1'b0;
            overrun_n = 1'b0;
        end

        if (bus.rxclk_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = 4'd1;
                    end
                end
                START: begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else if (cnt == MID_SAMPLE) begin
                        state_n   = DATA;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                DATA: begin
                    cnt_n = cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        cnt_n     = '0;
                        shift_n   = {rx_s, shift[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                        if (bit_idx == BIT_LAST) state_n = AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    cnt_n = cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        cnt_n        = '0;
                        parity_err_n = ((^shift) ^ rx_s) != PARITY_ODD;
                        state_n      = STOP;
                    end
                end
`endif
                STOP: begin
                    cnt_n = cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                        if (rx_s) begin
                            data_n      = shift;
                            rdy_n       = 1'b1;
                            frame_err_n = 1'b0;
                            if (rdy_q && !bus.rdy_clr) overrun_n = 1'b1;
                        end else begin
                            frame_err_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frame checks for uart_rx against a frame-level model
module tb_uart_rx;

    logic clock50 = 1'b0;
    logic reset   = 1'b1;
    uart_rx_if bus ();

    uart_rx dut (
        .clock50 (clock50),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clock50 = ~clock50;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] m_data;
    logic       m_rdy, m_fe, m_ov, m_pe;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},       bus.data,              m_data);
        check({tag, ".rdy"},        {7'd0, bus.rdy},       {7'd0, m_rdy});
        check({tag, ".frame_err"},  {7'd0, bus.frame_err}, {7'd0, m_fe});
        check({tag, ".overrun"},    {7'd0, bus.overrun},   {7'd0, m_ov});
        check({tag, ".parity_err"}, {7'd0, bus.parity_err}, {7'd0, m_pe});
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
    endtask

    // One oversample period: three quiet clocks then the strobe clock.
    task automatic tick(input bit clr);
        repeat (3) @(posedge clock50);
        #1 bus.rxclk_en = 1'b1;
        bus.rdy_clr = clr;
        @(posedge clock50);
        #1 bus.rxclk_en = 1'b0;
        bus.rdy_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic clear_pulse();
        @(posedge clock50);
        #1 bus.rdy_clr = 1'b1;
        @(posedge clock50);
        #1 bus.rdy_clr = 1'b0;
        m_rdy = 1'b0;
        m_ov  = 1'b0;
    endtask

    // Bit b of the frame is sampled on its 8th tick (tick 7) counted from its first tick.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                              input int stop_ticks, input bit clr_at_stop, input int abort_at);
        logic q[$];
        int   total;
        int   nt;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
        q.push_back(par_bit);
`endif
        q.push_back(stop_bit);
        total = 0;
        for (int j = 0; j < q.size(); j++) begin
            bus.rx = q[j];
            nt = (j == q.size() - 1) ? stop_ticks : 16;
            for (int t = 0; t < nt; t++) begin
                if (abort_at >= 0 && total == abort_at) return;
                if (j == q.size() - 1 && t == 7) begin
                    check("pre_stop.rdy", {7'd0, bus.rdy}, {7'd0, m_rdy});
                    check("pre_stop.data", bus.data, m_data);
                    tick(clr_at_stop);
`ifdef UART_RX_PARITY_EN
                    m_pe = (^b) ^ par_bit;
`endif
                    if (stop_bit) begin
                        m_ov   = clr_at_stop ? 1'b0 : (m_ov | m_rdy);
                        m_rdy  = 1'b1;
                        m_data = b;
                        m_fe   = 1'b0;
                    end else begin
                        m_fe = 1'b1;
                        if (clr_at_stop) begin
                            m_rdy = 1'b0;
                            m_ov  = 1'b0;
                        end
                    end
                    check("at_stop.rdy", {7'd0, bus.rdy}, {7'd0, m_rdy});
                end else begin
                    tick(1'b0);
                end
                total++;
            end
        end
        bus.rx = 1'b1;
    endtask

    logic [7:0] rb;
    logic       rstop;
    logic       rclr;
    int         rticks;

    initial begin
        bus.rx = 1'b1; bus.rxclk_en = 1'b0; bus.rdy_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clock50);
        #1 check_all("reset");
        reset = 1'b0;
        idle(3);

        send_frame(8'hA5, 1'b1, 1'b0, 16, 1'b0, -1);
        check_all("a5");

        clear_pulse();
        bus.rx = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0);
        idle(20);
        check_all("glitch");
        send_frame(8'h3C, 1'b1, 1'b0, 16, 1'b0, -1);
        check_all("3c");

        clear_pulse();
        send_frame(8'h55, 1'b0, 1'b0, 8, 1'b0, -1);
        idle(2);
        check_all("bad_stop");

        clear_pulse();
        send_frame(8'h01, 1'b1, 1'b1, 8, 1'b0, -1);
        send_frame(8'hFE, 1'b1, 1'b1, 16, 1'b0, -1);
        check_all("overrun");
        clear_pulse();
        check_all("clr");

        send_frame(8'h5A, 1'b1, 1'b0, 16, 1'b0, -1);
        send_frame(8'h81, 1'b1, 1'b0, 16, 1'b0, 4 * 16 + 8);
        #1 reset = 1'b1;
        #2 model_reset();
        check_all("mid_reset");
        bus.rx = 1'b1;
        repeat (2) @(posedge clock50);
        #1 reset = 1'b0;
        idle(3);
        send_frame(8'h81, 1'b1, 1'b0, 16, 1'b0, -1);
        check_all("81");

        send_frame(8'h9C, 1'b1, 1'b0, 16, 1'b1, -1);
        check_all("clr_vs_set");

        for (int k = 0; k < 8; k++) begin
            rb     = 8'($urandom);
            rstop  = ($urandom_range(0, 4) != 0);
            rclr   = ($urandom_range(0, 3) == 0);
            rticks = rstop ? int'($urandom_range(8, 16)) : 8;
            if ($urandom_range(0, 1) == 1) clear_pulse();
            send_frame(rb, rstop, ^rb, rticks, rclr, -1);
            if (!rstop) idle(2);
            check_all("rand");
        end

`ifdef UART_RX_PARITY_EN
        clear_pulse();
        send_frame(8'h07, 1'b1, 1'b1, 16, 1'b0, -1);
        check_all("par_ok");
        send_frame(8'h07, 1'b1, 1'b0, 16, 1'b0, -1);
        check_all("par_bad");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the MIPS32 system's serial port.
- Consumes the 16x-oversample strobe rxclk_en from the baud-rate generator, which is defined by the `BAUDRATE macro and the 50 MHz clock.
- Synchronises the asynchronous rx line, frames start/data/stop bits, and presents a received byte with a sticky ready flag that the bus/MMIO side clears.
- It is the receiving end of the serial link whose transmit timing comes from txclk_en.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- OVERSAMPLE, 16, rxclk_en ticks per bit period.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clock50  input  1  system clock, 50 MHz, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- rxclk_en  input  1  one-clock strobe at 16x the baud rate.
- rx  input  1  serial line, asynchronous, idles high.
- rdy_clr  input  1  one-clock pulse that clears rdy and overrun.
- data  output  8  last good received byte.
- rdy  output  1  a new byte is valid in data.
- frame_err  output  1  the last frame had a low stop bit.
- overrun  output  1  a byte completed while rdy was still 1.
- parity_err  output  1  parity mismatch on the last frame; tied 0 without the macro.

Behaviour:
- Interface: one clock, clock50. Reset is asynchronous and active-high, on port reset.
- Reset values:
  - data = 0, rdy = 0, frame_err = 0, overrun = 0, parity_err = 0.
  - Synchroniser flops = 1.
  - State = IDLE; sample counter, bit index and shift register = 0.
- Input path: rx passes through a 2-flop synchroniser to rx_s. Only rx_s is used. This adds 2 clocks of latency.
- All state advances happen only in clocks where rxclk_en = 1. Otherwise everything holds, except the rdy_clr handling.
- IDLE:
  - If rx_s = 0: go to START, cnt <= 1.
- START (mid-bit check of the start bit):
  - If rx_s = 1: back to IDLE. This is glitch rejection; no flags change.
  - Else if cnt = 7: go to DATA, cnt <= 0, bit index <= 0.
  - Else: cnt <= cnt + 1.
- DATA:
  - cnt increments on each tick.
  - At cnt = 15: shift <= {rx_s, shift[7:1]}, cnt <= 0, bit index <= bit index + 1.
  - After bit index 7 is sampled: go to PARITY if the macro is defined, else STOP.
  - Each sample therefore lands 16 ticks after the previous mid-bit point.
- STOP, sampled at cnt = 15, then return to IDLE:
  - rx_s = 1: data <= shift, rdy <= 1, frame_err <= 0. If rdy was already 1, overrun <= 1 and data is still overwritten with the newest byte.
  - rx_s = 0: frame_err <= 1. data, rdy and overrun are unchanged.
- Back-to-back frames: IDLE can detect the next start bit on the tick right after the stop sample.
- rdy_clr:
  - When asserted, rdy <= 0 and overrun <= 0, independent of rxclk_en.
  - If it coincides with a new byte being set, set wins: rdy = 1 and overrun = 0.
- Counter width: cnt is 4 bits and wraps naturally at 15 -> 0. Bit index is 3 bits, plus a terminal compare.
- Reset mid-frame: the frame is abandoned immediately and outputs return to their reset values.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8 data bits + parity + stop. A PARITY state sits between DATA and STOP and samples at cnt = 15.
  - The expected parity bit makes the total count of 1s even when PARITY_ODD = 0, or odd when PARITY_ODD = 1.
  - parity_err updates at the parity sample.
  - A byte with a parity error still loads data and sets rdy if the stop bit is good.
- Not defined:
  - No PARITY state; 8N1 framing only.
  - parity_err is constant 0.

Decomposition:
- Package uart_pkg holds:
  - State encodings: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, in a 3-bit type.
  - Constants OVERSAMPLE_LAST = 15, MID_SAMPLE = 7, DATA_BITS = 8.
- One sub-module, sync2: the 2-flop synchroniser with reset value 1.

Test Plan:
- Send 0xA5 as 8N1 with a 16-tick bit period -> data = 0xA5, rdy = 1, frame_err = 0, rdy rises exactly at the stop mid-sample tick.
- rx low for 4 ticks, then high -> stays IDLE, rdy = 0, no flag change; then send 0x3C -> data = 0x3C.
- Send 0x55 with the stop bit forced low -> frame_err = 1, rdy = 0, data keeps its previous value.
- Send 0x01 then 0xFE back-to-back without rdy_clr -> data = 0xFE, rdy = 1, overrun = 1; rdy_clr pulse -> rdy = 0, overrun = 0.
- Assert reset during data bit 3 of 0x81 -> all outputs 0 immediately; after release, send 0x81 -> data = 0x81.
- With UART_RX_PARITY_EN and PARITY_ODD = 0: send 0x07 with parity bit 1 -> parity_err = 0; with parity bit 0 -> parity_err = 1, rdy = 1.
